// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/redirect sequencing, next-PC selection,
// misaligned-target detection and an accepted-fetch counter.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 4,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cond,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             mret_req,
  input  logic [XLEN-1:0]  epc_in,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  normal_pc,
  output logic [XLEN-1:0]  jal_branch_pc,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            fire;
  logic            transfer;
  logic            misaligned;
  logic            misalign_set;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;

  assign fetch_valid   = (state == RUN);
  assign fire          = fetch_valid & fetch_ready;
  assign normal_pc     = pc + XLEN'(4);
  assign jal_branch_pc = pc + imm;

  // Sequential pc+4 is excluded from the alignment check; only real transfers are tested.
  always_comb begin
    target   = normal_pc;
    transfer = 1'b1;
    if (mret_req) begin
      target = epc_in;
    end else if (cond == 2'b01) begin
      target = jal_branch_pc;
    end else if (cond[1]) begin
      target = {alu_out[XLEN-1:1], 1'b0};
    end else begin
      transfer = 1'b0;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    if (transfer) begin
      if (IALIGN == 2) begin
        misaligned = target[0];
      end else begin
        misaligned = target[1];
      end
    end
  end

  // Trap redirect wins over any fetch outcome; the fetch itself may still be counted.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    misalign_set = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (trap_req) begin
          state_next = REDIR;
          pc_next    = trap_vec;
        end else if (fire) begin
          if (misaligned) begin
            misalign_set = 1'b1;
          end else begin
            pc_next = target;
          end
        end
      end
      REDIR: begin
        if (trap_req) begin
          state_next = REDIR;
          pc_next    = trap_vec;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
      fetch_cnt     <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      misalign_exc <= misalign_set;
      if (misalign_set) begin
        misalign_addr <= target;
      end
      if (fire) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table on the default instance, then random
// traffic on a default and a non-default instance against a reference model.
module tb_pc_gen;

  localparam logic [31:0] RV_B = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  cond;
  logic [31:0] imm, alu_out, trap_vec, epc_in;
  logic        trap_req, mret_req, fetch_ready;

  logic [31:0] pc_a, normal_pc_a, jal_pc_a, maddr_a, cnt_a;
  logic        valid_a, exc_a;
  logic [31:0] pc_b, normal_pc_b, jal_pc_b, maddr_b;
  logic [2:0]  cnt_b;
  logic        valid_b, exc_b;

  int total = 0;
  int bad   = 0;

  pc_gen u_dut_a (
    .clk(clk), .rst(rst), .cond(cond), .imm(imm), .alu_out(alu_out),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req),
    .epc_in(epc_in), .fetch_ready(fetch_ready), .pc(pc_a),
    .fetch_valid(valid_a), .normal_pc(normal_pc_a), .jal_branch_pc(jal_pc_a),
    .misalign_exc(exc_a), .misalign_addr(maddr_a), .fetch_cnt(cnt_a)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(RV_B), .IALIGN(2), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .cond(cond), .imm(imm), .alu_out(alu_out),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req),
    .epc_in(epc_in), .fetch_ready(fetch_ready), .pc(pc_b),
    .fetch_valid(valid_b), .normal_pc(normal_pc_b), .jal_branch_pc(jal_pc_b),
    .misalign_exc(exc_b), .misalign_addr(maddr_b), .fetch_cnt(cnt_b)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cond;
    logic [31:0] imm, alu, tvec, epc;
    logic        trap, mret, ready;
    logic [31:0] e_pc;
    logic        e_valid, e_exc;
    logic [31:0] e_maddr, e_cnt;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(int r, int c, int unsigned im, int unsigned al,
                              int unsigned tv, int unsigned ep, int tr, int mr,
                              int rd, int unsigned epc_exp, int ev, int ee,
                              int unsigned em, int unsigned ec);
    vec_t v;
    v.rst = 1'(r);      v.cond = 2'(c);      v.imm = im;     v.alu = al;
    v.tvec = tv;        v.epc = ep;          v.trap = 1'(tr); v.mret = 1'(mr);
    v.ready = 1'(rd);   v.e_pc = epc_exp;    v.e_valid = 1'(ev);
    v.e_exc = 1'(ee);   v.e_maddr = em;      v.e_cnt = ec;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [1:0] c, input logic [31:0] im,
                               input logic [31:0] al, input logic [31:0] tv,
                               input logic [31:0] ep, input logic tr, input logic mr,
                               input logic rd);
    rst = r; cond = c; imm = im; alu_out = al; trap_vec = tv; epc_in = ep;
    trap_req = tr; mret_req = mr; fetch_ready = rd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = boot, 1 = running, 2 = redirect; index 0/1 = instance a/b.
  longint m_pc[2], m_cnt[2], m_maddr[2];
  int     m_phase[2];
  bit     m_exc[2];
  longint rv[2] = '{0, 64'h1000};
  int     ia[2] = '{4, 2};
  int     cw[2] = '{32, 3};
  localparam longint MOD = 64'h1_0000_0000;

  task automatic modelStep(input int i);
    longint tgt;
    bit     fired, bad_align, is_xfer;
    if (rst) begin
      m_phase[i] = 0; m_pc[i] = rv[i]; m_cnt[i] = 0; m_exc[i] = 0; m_maddr[i] = 0;
      return;
    end
    fired = (m_phase[i] == 1) && fetch_ready;
    if (fired) m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << cw[i]);
    m_exc[i] = 0;
    if (m_phase[i] != 0 && trap_req) begin
      m_pc[i] = trap_vec;
      m_phase[i] = 2;
    end else if (m_phase[i] != 1) begin
      m_phase[i] = 1;
    end else if (fired) begin
      is_xfer = 1;
      if (mret_req)          tgt = epc_in;
      else if (cond == 2'd1) tgt = (m_pc[i] + longint'(imm)) % MOD;
      else if (cond >= 2'd2) tgt = longint'(alu_out) - (longint'(alu_out) % 2);
      else begin tgt = (m_pc[i] + 4) % MOD; is_xfer = 0; end
      bad_align = is_xfer && (ia[i] == 4 ? ((tgt / 2) % 2 == 1) : (tgt % 2 == 1));
      if (bad_align) begin
        m_exc[i] = 1;
        m_maddr[i] = tgt;
      end else begin
        m_pc[i] = tgt;
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 0, 0, 'h80, 0, 1, 1, 1,           0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,              0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,              4, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,            'h8, 1, 0, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,            'hC, 1, 0, 0, 3);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,           'h10, 1, 0, 0, 4);
    vecs[6]  = mk(0, 1, 'hF0, 0, 0, 0, 0, 0, 1,       'h100, 1, 0, 0, 5);
    vecs[7]  = mk(0, 1, 'hFFFFFFF0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0, 0, 5);
    vecs[8]  = mk(0, 1, 'hFFFFFFF0, 7, 0, 3, 0, 0, 0, 'h100, 1, 0, 0, 5);
    vecs[9]  = mk(0, 1, 'hFFFFFFF0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0, 0, 5);
    vecs[10] = mk(0, 1, 'hFFFFFFF0, 0, 0, 0, 0, 0, 1,  'hF0, 1, 0, 0, 6);
    vecs[11] = mk(0, 2, 0, 'h203, 0, 0, 0, 0, 1,        'hF0, 1, 1, 'h202, 7);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            'hF0, 1, 0, 'h202, 7);
    vecs[13] = mk(0, 0, 0, 0, 'h80, 0, 1, 0, 0,         'h80, 0, 0, 'h202, 7);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            'h80, 1, 0, 'h202, 7);
    vecs[15] = mk(0, 1, 'h10, 0, 0, 'h44, 0, 1, 1,      'h44, 1, 0, 'h202, 8);
    vecs[16] = mk(0, 2, 0, 'hFFFFFFFD, 0, 0, 0, 0, 1, 'hFFFFFFFC, 1, 0, 'h202, 9);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,              0, 1, 0, 'h202, 10);
    vecs[18] = mk(1, 0, 0, 0, 'h80, 0, 1, 0, 1,           0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 'h900, 0, 1, 0, 0,          0, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 'h200, 0, 1, 0, 1,       'h200, 0, 0, 0, 1);
    vecs[21] = mk(0, 0, 0, 0, 'h300, 0, 1, 0, 1,       'h300, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,           'h300, 1, 0, 0, 1);
    vecs[23] = mk(0, 2, 0, 'h2, 'h400, 0, 1, 0, 1,     'h400, 0, 0, 0, 2);
    vecs[24] = mk(0, 1, 'h6, 0, 0, 0, 0, 0, 1,         'h400, 1, 0, 0, 2);
    vecs[25] = mk(0, 1, 'h6, 0, 0, 0, 0, 0, 1,         'h400, 1, 1, 'h406, 3);
    vecs[26] = mk(0, 2, 0, 0, 0, 'h500, 0, 1, 0,       'h400, 1, 0, 'h406, 3);
    vecs[27] = mk(0, 3, 0, 'h505, 0, 0, 0, 0, 1,       'h504, 1, 0, 'h406, 4);
    vecs[28] = mk(1, 1, 'h4, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,              0, 1, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].cond, vecs[k].imm, vecs[k].alu, vecs[k].tvec,
                    vecs[k].epc, vecs[k].trap, vecs[k].mret, vecs[k].ready);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d pc", k),          64'(pc_a),    64'(vecs[k].e_pc));
      checkOutput($sformatf("vec%0d fetch_valid", k), 64'(valid_a), 64'(vecs[k].e_valid));
      checkOutput($sformatf("vec%0d misalign_exc", k), 64'(exc_a),  64'(vecs[k].e_exc));
      checkOutput($sformatf("vec%0d misalign_addr", k), 64'(maddr_a), 64'(vecs[k].e_maddr));
      checkOutput($sformatf("vec%0d fetch_cnt", k),   64'(cnt_a),   64'(vecs[k].e_cnt));
    end

    // Hand sequence: combinational next-pc outputs follow the registered pc and live imm.
    applyStimulus(0, 2'd0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("seq normal_pc", 64'(normal_pc_a), 64'h4);
    checkOutput("seq jal_branch_pc", 64'(jal_pc_a), 64'hFFFF_FFF8);

    for (int n = 0; n < 800; n++) begin
      logic [31:0] r_imm, r_tv, r_ep;
      r_imm = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      r_tv  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      r_ep  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      applyStimulus(1'((n == 0) || ($urandom_range(0, 79) == 0)), 2'($urandom_range(0, 3)),
                    r_imm, $urandom, r_tv, r_ep, 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
      #1;
      if (n > 0) begin
        checkOutput($sformatf("rnd%0d a normal_pc", n), 64'(normal_pc_a), 64'((m_pc[0] + 4) % MOD));
        checkOutput($sformatf("rnd%0d a jal_branch_pc", n), 64'(jal_pc_a),
                    64'((m_pc[0] + longint'(imm)) % MOD));
        checkOutput($sformatf("rnd%0d b normal_pc", n), 64'(normal_pc_b), 64'((m_pc[1] + 4) % MOD));
        checkOutput($sformatf("rnd%0d b jal_branch_pc", n), 64'(jal_pc_b),
                    64'((m_pc[1] + longint'(imm)) % MOD));
      end
      @(posedge clk);
      #1;
      modelStep(0);
      modelStep(1);
      checkOutput($sformatf("rnd%0d a pc", n),            64'(pc_a),    64'(m_pc[0]));
      checkOutput($sformatf("rnd%0d a fetch_valid", n),   64'(valid_a), 64'(m_phase[0] == 1));
      checkOutput($sformatf("rnd%0d a misalign_exc", n),  64'(exc_a),   64'(m_exc[0]));
      checkOutput($sformatf("rnd%0d a misalign_addr", n), 64'(maddr_a), 64'(m_maddr[0]));
      checkOutput($sformatf("rnd%0d a fetch_cnt", n),     64'(cnt_a),   64'(m_cnt[0]));
      checkOutput($sformatf("rnd%0d b pc", n),            64'(pc_b),    64'(m_pc[1]));
      checkOutput($sformatf("rnd%0d b fetch_valid", n),   64'(valid_b), 64'(m_phase[1] == 1));
      checkOutput($sformatf("rnd%0d b misalign_exc", n),  64'(exc_b),   64'(m_exc[1]));
      checkOutput($sformatf("rnd%0d b misalign_addr", n), 64'(maddr_b), 64'(m_maddr[1]));
      checkOutput($sformatf("rnd%0d b fetch_cnt", n),     64'(cnt_b),   64'(m_cnt[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of all address and data ports.
REQ-002 Parameter RESET_VEC, default 0, first PC fetched after reset.
REQ-003 Parameter IALIGN, default 4, target alignment in bytes (legal values: 2 or 4).
REQ-004 Parameter CNT_W, default 32, width of the accepted-fetch counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 cond  in  2  next-PC select: 00 pc+4, 01 pc+imm (jal / taken branch), 1x jalr (alu_out).
REQ-008 imm  in  XLEN  branch/jal offset.
REQ-009 alu_out  in  XLEN  jalr target.
REQ-010 trap_req  in  1  trap redirect request.
REQ-011 trap_vec  in  XLEN  trap handler address.
REQ-012 mret_req  in  1  return-from-trap request.
REQ-013 epc_in  in  XLEN  mret return address.
REQ-014 fetch_ready  in  1  instruction memory accepts the current pc.
REQ-015 pc  out  XLEN  current fetch address.
REQ-016 fetch_valid  out  1  pc is a valid fetch request.
REQ-017 normal_pc  out  XLEN  pc+4, combinational.
REQ-018 jal_branch_pc  out  XLEN  pc+imm, combinational.
REQ-019 misalign_exc  out  1  one-cycle pulse on a misaligned control-transfer target.
REQ-020 misalign_addr  out  XLEN  offending target, held until the next misalign_exc.
REQ-021 fetch_cnt  out  CNT_W  number of accepted fetches.

Function
REQ-022 States: BOOT, RUN, REDIR; fetch_valid SHALL be 1 only in RUN.
REQ-023 BOOT SHALL last exactly one cycle with pc=RESET_VEC, then go to RUN.
REQ-024 A fetch is accepted ("fire") in a cycle where fetch_valid=1 and fetch_ready=1.
REQ-025 In RUN without fire, pc SHALL hold and fetch_valid SHALL stay 1 (request stable).
REQ-026 cond, imm, alu_out and epc_in SHALL be sampled only on fire; on non-fire cycles they are ignored.
REQ-027 On fire, target selection SHALL follow this priority: mret_req -> epc_in; else cond=01 -> pc+imm; else cond=1x -> alu_out with bit 0 forced to 0; else pc+4.
REQ-028 All additions SHALL be modulo 2^XLEN; wrap past the top address SHALL not be flagged.
REQ-029 A target is misaligned if (IALIGN=4 and target[1]=1) or (IALIGN=2 and target[0]=1, checked after the jalr bit-0 clear).
REQ-030 On a misaligned target: misalign_exc SHALL pulse for one cycle, misalign_addr SHALL load the target, and pc SHALL hold (no update).
REQ-031 pc+4 SHALL never raise misalign_exc.
REQ-032 trap_req SHALL be honoured in any non-BOOT cycle regardless of fetch_ready, and SHALL override mret_req, cond and misalignment in that cycle.
REQ-033 On trap_req: pc <= trap_vec, the FSM SHALL enter REDIR for one cycle (fetch_valid=0), then return to RUN.
REQ-034 trap_req during REDIR SHALL reload pc with the new trap_vec and extend REDIR by one cycle.
REQ-035 fetch_cnt SHALL increment by 1 on every fire, SHALL wrap at 2^CNT_W, and SHALL count the fire cycle that coincides with a trap.
REQ-036 normal_pc and jal_branch_pc SHALL be derived from the registered pc.

Reset
REQ-037 rst SHALL override all other inputs in the cycle it is sampled.
REQ-038 After reset: state=BOOT, pc=RESET_VEC, fetch_valid=0, misalign_exc=0, misalign_addr=0, fetch_cnt=0.
REQ-039 rst asserted mid-stall or in REDIR SHALL discard any pending request; no misalign_exc SHALL pulse in the reset cycle.

Verification
REQ-040 Reset, then fetch_ready=1 with cond=00 for 4 cycles -> pc 0x0, 0x4, 0x8, 0xC, 0x10; fetch_cnt=4.
REQ-041 pc=0x100, cond=01, imm=0xFFFFFFF0, fetch_ready held low for 3 cycles then high -> pc stays 0x100 for the 3 cycles, then 0xF0.
REQ-042 IALIGN=4, cond=10, alu_out=0x203 -> target 0x202, misalign_exc=1 for one cycle, misalign_addr=0x202, pc unchanged.
REQ-043 trap_req with trap_vec=0x80 while fetch_ready=0 -> pc=0x80, fetch_valid=0 for one cycle, then 1.
REQ-044 mret_req and cond=01 on the same fire, epc_in=0x44 -> pc=0x44.
REQ-045 pc=0xFFFFFFFC, cond=00, fire -> pc=0x0 with no misalign_exc; rst asserted next cycle -> BOOT with pc=RESET_VEC.
